// File: rtl/bin_to_bcd_display_pkg.sv
// Shared definitions for the binary-to-BCD converter feeding the 8-digit
// seven-segment driver.
//   - state_t    : converter FSM state encoding (IDLE / SHIFT / DONE)
//   - DIGIT_W    : bits per BCD digit
//   - BCD_NINE   : the digit value used when a saturated result is shown
//   - int_digits : decimal digits needed to hold any IN_WIDTH-bit value,
//                  (w*301+999)/1000, i.e. ceil(w*log10(2)); the display top
//                  reuses it to size its own digit arrays.
package bin_to_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int          DIGIT_W  = 4;
    localparam logic [3:0]  BCD_NINE = 4'h9;

    function automatic int int_digits(input int width);
        return (width * 301 + 999) / 1000;
    endfunction

endpackage

// File: rtl/bin_to_bcd_display_if.sv
// Request/result bundle between a client and the binary-to-BCD converter.
//   start    : request a conversion (client -> converter)
//   bin_in   : unsigned value to convert, IN_WIDTH bits (client -> converter)
//   busy     : conversion in progress (converter -> client)
//   done     : one-cycle pulse, result valid from this cycle (converter -> client)
//   bcd_out  : DIGITS packed BCD digits, digit 0 in [3:0] (converter -> client)
//   overflow : value needs more than DIGITS decimal digits (converter -> client)
// Modports: master = client side, slave = converter side.
interface bin_to_bcd_display_if #(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = 8
) ();

    logic                  start;
    logic [IN_WIDTH-1:0]   bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );

endinterface

// File: rtl/bin_to_bcd_display_add3.sv
// One digit of the shift-and-add-3 step: a digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
//   digit_in  : current BCD digit (0..9 in a valid conversion)
//   digit_out : adjusted digit, ready to be shifted
// The add is 4-bit with no carry out: inputs are at most 9, so the largest
// result is 12.
module bin_to_bcd_display_add3
    import bin_to_bcd_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= DIGIT_W'(5)) ? digit_in + DIGIT_W'(3) : digit_in;

endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for the 8-digit
// seven-segment driver. A value captured on start is converted over
// IN_WIDTH shift cycles; the BCD result is then held on bcd_out until the
// next conversion completes.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset; aborts any conversion
//   bus   : bin_to_bcd_display_if.slave (start, bin_in, busy, done,
//           bcd_out, overflow)
// Parameters:
//   IN_WIDTH : width of the unsigned binary input (default 32)
//   DIGITS   : BCD digits presented on bcd_out (default 8)
// Configuration macro BCD_SATURATE_EN:
//   defined   -> an overflowing value shows as all nines on bcd_out
//   undefined -> bcd_out shows the low DIGITS digits (value mod 10**DIGITS)
//   overflow itself is the same in both builds.
// Timing: start accepted at edge k; the shift register runs IN_WIDTH shifts,
// spends one more SHIFT cycle with the count at IN_WIDTH, and on edge
// k+IN_WIDTH+1 loads bcd_out/overflow and enters DONE, so done is high in
// the cycle after that edge and busy covers SHIFT plus DONE.
module bin_to_bcd_display
    import bin_to_bcd_display_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bin_to_bcd_display_if.slave  bus
);

    localparam int INT_DIGITS = int_digits(IN_WIDTH);
    localparam int BCD_W      = DIGIT_W * INT_DIGITS;
    localparam int OUT_W      = DIGIT_W * DIGITS;
    localparam int CNT_W      = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH);

    state_t              state;
    state_t              state_next;

    logic [BCD_W-1:0]    bcd_q;
    logic [BCD_W-1:0]    bcd_adj;
    logic [IN_WIDTH-1:0] bin_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [OUT_W-1:0]    bcd_out_q;
    logic                overflow_q;

    logic [OUT_W-1:0]    low_digits;
    logic                ovf_now;
    logic [OUT_W-1:0]    bcd_sel;

    // ------------------------------------------------------------------
    // Add-3 adjustment on every digit in parallel, ahead of the shift.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_digit
        bin_to_bcd_display_add3 u_add3 (
            .digit_in  (bcd_q  [g*DIGIT_W +: DIGIT_W]),
            .digit_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // ------------------------------------------------------------------
    // Result selection. Any nonzero digit above the displayed ones means
    // the value does not fit on the display.
    // ------------------------------------------------------------------
    if (INT_DIGITS > DIGITS) begin : g_ovf
        assign low_digits = bcd_q[OUT_W-1:0];
        assign ovf_now    = |bcd_q[BCD_W-1:OUT_W];
    end else begin : g_no_ovf
        assign low_digits = OUT_W'(bcd_q);
        assign ovf_now    = 1'b0;
    end

`ifdef BCD_SATURATE_EN
    assign bcd_sel = ovf_now ? {DIGITS{BCD_NINE}} : low_digits;
`else
    assign bcd_sel = low_digits;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. start is only looked at in IDLE, so a request
    // during SHIFT or DONE is dropped rather than queued.
    // ------------------------------------------------------------------
    // NOTE: the default assignment first keeps this block free of latches
    // on any path the case statement does not cover.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.start)          state_next = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_LAST)  state_next = ST_DONE;
            ST_DONE:                          state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: working register {bcd, bin}, iteration count, held result.
    // ------------------------------------------------------------------
    // NOTE: every datapath register is reset (there is no memory here), so
    // the outputs never carry X and an aborted conversion leaves no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        bin_q <= bus.bin_in;
                        bcd_q <= '0;
                        cnt_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q != CNT_LAST) begin
                        // The adjusted top digit never exceeds 7 here, so the
                        // bit shifted out of the top is always zero.
                        {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                        cnt_q          <= cnt_q + CNT_W'(1);
                    end else begin
                        bcd_out_q  <= bcd_sel;
                        overflow_q <= ovf_now;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DONE);
    assign bus.bcd_out  = bcd_out_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Directed self-checking bench for bin_to_bcd_display (IN_WIDTH=32,
// DIGITS=8). Honours BCD_SATURATE_EN for the overflow expectations.
module tb_bin_to_bcd_display;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    bin_to_bcd_display_if #(.IN_WIDTH(32), .DIGITS(8)) bus ();

    bin_to_bcd_display #(.IN_WIDTH(32), .DIGITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Entered at a negedge; raises start there so calls chain back-to-back
    // (start in the cycle right after the previous done). Returns at the
    // negedge after done. inject > 0 re-pulses start with bin_in=5 that many
    // cycles into the conversion.
    task automatic run(input string tag, input logic [31:0] value,
                       input logic [31:0] exp_bcd, input logic exp_ovf,
                       input int inject);
        int edges;
        int busy_cnt;
        bus.start  = 1'b1;
        bus.bin_in = value;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bin_in = 32'hDEAD_BEEF;
        edges    = 0;
        busy_cnt = 0;
        while (1) begin
            if (bus.busy) busy_cnt++;
            if (bus.done || edges >= 100) break;
            @(negedge clk);
            edges++;
            bus.start = (inject > 0 && edges == inject);
            if (bus.start) bus.bin_in = 32'd5;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, edges, 33);
        check({tag, "_done"}, bus.done, 1'b1);
        check({tag, "_bcd"}, bus.bcd_out, exp_bcd);
        check({tag, "_ovf"}, bus.overflow, exp_ovf);
        check({tag, "_busy_cycles"}, busy_cnt, 34);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 1'b0);
        check({tag, "_idle"}, bus.busy, 1'b0);
        check({tag, "_held"}, bus.bcd_out, exp_bcd);
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_bcd", bus.bcd_out, 32'h0);
        check("rst_ovf", bus.overflow, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run("zero",  32'd0,        32'h00000000, 1'b0, 0);
        run("mid",   32'd12345678, 32'h12345678, 1'b0, 0);
        run("ten",   32'd10,       32'h00000010, 1'b0, 0);
        run("max8",  32'd99999999, 32'h99999999, 1'b0, 0);
`ifdef BCD_SATURATE_EN
        run("ovf1e8", 32'd100000000, 32'h99999999, 1'b1, 0);
        run("ovfmax", 32'hFFFFFFFF,  32'h99999999, 1'b1, 0);
`else
        run("ovf1e8", 32'd100000000, 32'h00000000, 1'b1, 0);
        run("ovfmax", 32'hFFFFFFFF,  32'h94967295, 1'b1, 0);
`endif
        run("date",  32'd20230915, 32'h20230915, 1'b0, 0);
        run("ignore_start", 32'd42, 32'h00000042, 1'b0, 10);

        // Reset in the middle of a conversion discards it and clears outputs.
        bus.start  = 1'b1;
        bus.bin_in = 32'd123456;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", bus.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_bcd", bus.bcd_out, 32'h0);
        check("midrst_ovf", bus.overflow, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        run("after_rst", 32'd7, 32'h00000007, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
